fb_write_arbiter: RTL

- Shares the single framebuffer dpram write port among N_REQ pixel writers, such as the video generator and a future sprite/blit engine.
- Uses a round-robin valid/ready arbiter with a registered write-port output.
- Includes a built-in full-framebuffer clear sequencer that fills every address with one colour at one pixel per clock.
- Sits between the writers and dpram wr_en/wr_addr/wr_in on the logic clock domain.

---
 rtl/fb_pkg.sv | 10 +
 rtl/rr_arbiter.sv | 27 ++
 rtl/fb_write_arbiter.sv | 98 +++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// fb_pkg: framebuffer geometry, pixel/address types and write-arbiter state encoding.
package fb_pkg;
   localparam int DISPLAY_WIDTH  = 320;
   localparam int DISPLAY_HEIGHT = 240;
   localparam int FB_DATA_N      = DISPLAY_WIDTH * DISPLAY_HEIGHT;
   localparam int FB_ADDR_BITS   = $clog2(FB_DATA_N);
   typedef logic [15:0] pixel_t;
   typedef logic [FB_ADDR_BITS-1:0] fb_addr_t;
   typedef enum logic {ARB = 1'b0, CLEAR = 1'b1} arb_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick; searches from i_ptr+1 upward modulo N.
module rr_arbiter #(
   parameter int N  = 2,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic [N-1:0]  o_gnt,
   output logic [IW-1:0] o_idx,
   output logic          o_any
);
   always_comb begin
      int j;
      o_gnt = '0;
      o_idx = '0;
      o_any = 1'b0;
      j = 0;
      for (int k = 1; k <= N; k++) begin
         j = (int'(i_ptr) + k) % N;
         if (!o_any && i_req[j]) begin
            o_any    = 1'b1;
            o_gnt[j] = 1'b1;
            o_idx    = IW'(j);
         end
      end
   end
endmodule

// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter: shares the framebuffer write port among N_REQ writers with a
// round-robin grant, a registered write port and a full-framebuffer clear sequencer.
import fb_pkg::*;
module fb_write_arbiter #(
   parameter int N_REQ      = 2,
   parameter int DATA_WIDTH = 16,
   parameter int DATA_N     = FB_DATA_N,
   parameter int ADDR_BITS  = $clog2(DATA_N)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [N_REQ-1:0]            req_valid,
   output logic [N_REQ-1:0]            req_ready,
   input  logic [N_REQ*ADDR_BITS-1:0]  req_addr,
   input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
   input  logic                        clear_start,
   input  logic [DATA_WIDTH-1:0]       clear_color,
   output logic                        clear_busy,
   output logic                        addr_err,
   output logic                        fb_wr_en,
   output logic [ADDR_BITS-1:0]        fb_wr_addr,
   output logic [DATA_WIDTH-1:0]       fb_wr_in
);
   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   arb_state_t            r_state;
   logic [IW-1:0]         r_rr_ptr;
   logic [ADDR_BITS-1:0]  r_cnt;
   logic [DATA_WIDTH-1:0] r_color;
   logic                  r_busy, r_err, r_wr_en;
   logic [ADDR_BITS-1:0]  r_wr_addr;
   logic [DATA_WIDTH-1:0] r_wr_in;
   logic [N_REQ-1:0]      w_gnt;
   logic [IW-1:0]         w_idx;
   logic                  w_any, w_open, w_xfer, w_in_range, w_last;
   logic [ADDR_BITS-1:0]  w_addr;
   logic [DATA_WIDTH-1:0] w_data;
   rr_arbiter #(.N(N_REQ), .IW(IW)) u_rr (
      .i_req(req_valid),
      .i_ptr(r_rr_ptr),
      .o_gnt(w_gnt),
      .o_idx(w_idx),
      .o_any(w_any)
   );
   // clear_start wins over any same-cycle request
   assign w_open     = (r_state == ARB) && !clear_start;
   assign req_ready  = w_open ? w_gnt : '0;
   assign w_xfer     = w_open && w_any;
   assign w_addr     = req_addr[int'(w_idx)*ADDR_BITS +: ADDR_BITS];
   assign w_data     = req_data[int'(w_idx)*DATA_WIDTH +: DATA_WIDTH];
   assign w_in_range = 32'(w_addr) < DATA_N;
   assign w_last     = r_cnt == ADDR_BITS'(DATA_N - 1);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ARB;
         r_rr_ptr  <= IW'(N_REQ - 1);
         r_cnt     <= '0;
         r_color   <= '0;
         r_busy    <= 1'b0;
         r_err     <= 1'b0;
         r_wr_en   <= 1'b0;
         r_wr_addr <= '0;
         r_wr_in   <= '0;
      end else begin
         r_wr_en <= 1'b0;
         r_err   <= 1'b0;
         if (r_state == ARB) begin
            if (clear_start) begin
               r_state <= CLEAR;
               r_color <= clear_color;
               r_busy  <= 1'b1;
               r_cnt   <= '0;
            end else if (w_xfer) begin
               r_rr_ptr <= w_idx;
               r_wr_en  <= w_in_range;
               r_err    <= !w_in_range;
               if (w_in_range) begin
                  r_wr_addr <= w_addr;
                  r_wr_in   <= w_data;
               end
            end
         end else begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_cnt;
            r_wr_in   <= r_color;
            r_cnt     <= w_last ? '0 : r_cnt + 1'b1;
            if (w_last) begin
               r_state <= ARB;
               r_busy  <= 1'b0;
            end
         end
      end
   end
   assign clear_busy = r_busy;
   assign addr_err   = r_err;
   assign fb_wr_en   = r_wr_en;
   assign fb_wr_addr = r_wr_addr;
   assign fb_wr_in   = r_wr_in;
endmodule
